// File: rtl/mips_processor_pkg.sv
// mips_processor_pkg: opcodes, instruction field positions and the program ROM contents
package mips_processor_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_LI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SLL, OP_MOV, OP_COMP
  } opcode_t;
  localparam int OP_LSB = 28;
  localparam int RD_LSB = 24;
  localparam int RS_LSB = 20;
  localparam int RT_LSB = 16;
  localparam int IMM_W  = 16;
  function automatic logic [31:0] enc(input opcode_t op, input logic [3:0] rd, input logic [3:0] rs,
                                      input logic [3:0] rt, input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rom_word(input int a);
    case (a)
      1:  return enc(OP_LI,   4'd0,  4'd0, 4'd0, 16'hFFFF);
      2:  return enc(OP_LI,   4'd1,  4'd0, 4'd0, 16'd1);
      3:  return enc(OP_LI,   4'd2,  4'd0, 4'd0, 16'd2);
      4:  return enc(OP_LI,   4'd3,  4'd0, 4'd0, 16'd0);
      5:  return enc(OP_LI,   4'd4,  4'd0, 4'd0, 16'd3);
      6:  return enc(OP_LI,   4'd5,  4'd0, 4'd0, 16'd4);
      7:  return enc(OP_ADD,  4'd6,  4'd1, 4'd0, 16'd0);
      8:  return enc(OP_NOT,  4'd7,  4'd4, 4'd0, 16'd0);
      9:  return enc(OP_SUB,  4'd8,  4'd0, 4'd1, 16'd0);
      10: return enc(OP_ADD,  4'd8,  4'd1, 4'd8, 16'd0);
      11: return enc(OP_SUB,  4'd8,  4'd8, 4'd2, 16'd0);
      12: return enc(OP_XOR,  4'd10, 4'd0, 4'd0, 16'd0);
      13: return enc(OP_AND,  4'd10, 4'd2, 4'd4, 16'd0);
      14: return enc(OP_COMP, 4'd10, 4'd3, 4'd0, 16'd0);
      15: return enc(OP_MOV,  4'd11, 4'd5, 4'd0, 16'd0);
      16: return enc(OP_SLL,  4'd11, 4'd0, 4'd0, 16'd1);
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational ALU; ADD/SUB share one 33-bit adder (SUB = a + ~b + 1)
module mips_alu
  import mips_processor_pkg::*;
#(
  parameter int W = 32
) (
  input  opcode_t        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [4:0]     shamt,
  output logic [W-1:0]   result,
  output logic           carry,
  output logic           overflow,
  output logic           eq
);
  logic [W-1:0] bb;
  logic [W:0]   sum;
  always_comb begin
    bb       = (op == OP_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op == OP_SUB};
    carry    = sum[W];
    overflow = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    eq       = a == b;
    case (op)
      OP_LI:   result = b;
      OP_ADD:  result = sum[W-1:0];
      OP_SUB:  result = sum[W-1:0];
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SLL:  result = a << shamt;
      OP_MOV:  result = a;
      OP_COMP: result = {{(W-1){1'b0}}, eq};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/mips_processor.sv
// mips_processor: two-stage fetch/execute core with DMA-style IMEM load from the program ROM
module mips_processor
  import mips_processor_pkg::*;
#(
  parameter int aBit = 6,
  parameter int nBit = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            request,
  input  logic [aBit-1:0] addr,
  output logic [nBit-1:0] dout,
  output logic            acknowledge,
  output logic            carry,
  output logic            overflow,
  output logic            equal
);
  logic [nBit-1:0] imem [2**aBit];
  logic [nBit-1:0] regs [16];
  logic [aBit-1:0] pc;
  logic [nBit-1:0] ir;
  opcode_t         op;
  logic [nBit-1:0] a, b, res;
  logic            alu_c, alu_v, alu_eq, we;
  assign acknowledge = request;
  assign op = opcode_t'(ir[OP_LSB +: 4]);
  assign a  = regs[ir[RS_LSB +: 4]];
  assign b  = (op == OP_LI) ? {{(nBit-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]} : regs[ir[RT_LSB +: 4]];
  assign we = (op != OP_NOP) && (op <= OP_COMP);
  mips_alu #(.W(nBit)) alu (
    .op(op), .a(a), .b(b), .shamt(ir[4:0]),
    .result(res), .carry(alu_c), .overflow(alu_v), .eq(alu_eq)
  );
  // IMEM survives reset so a loaded program can be rerun
  always_ff @(posedge clk)
    if (request) imem[addr] <= rom_word(int'(addr));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= aBit'(1);
      ir       <= '0;
      dout     <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      equal    <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (!request) begin
      ir <= imem[pc];
      pc <= pc + 1'b1;
      if (we) begin
        regs[ir[RD_LSB +: 4]] <= res;
        dout                  <= res;
      end
      if (op == OP_ADD || op == OP_SUB) begin
        carry    <= alu_c;
        overflow <= alu_v;
      end
      if (op == OP_COMP) equal <= alu_eq;
    end
  end
endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: directed load/execute/reset/stall bench with a dout scoreboard
module tb_mips_processor;
  logic        clk = 0, rst = 1, request = 0;
  logic [5:0]  addr = '0;
  logic [31:0] dout;
  logic        acknowledge, carry, overflow, equal;
  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [31:0] exp_seq [16] = '{32'hFFFFFFFF, 32'h1, 32'h2, 32'h0, 32'h3, 32'h4, 32'h0, 32'hFFFFFFFC,
                                32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h2, 32'h0, 32'h4, 32'hFFFFFFFE};
  mips_processor dut (
    .clk(clk), .rst(rst), .request(request), .addr(addr), .dout(dout),
    .acknowledge(acknowledge), .carry(carry), .overflow(overflow), .equal(equal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pop_chk();
    exp_t e;
    checks++;
    assert (q.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, dout, e.v);
    end
  endtask
  // executes instructions first+1..last+1 of the program; fetch adds the fetch-only first edge
  task automatic run(input string tag, input int first, input int last, input bit fetch);
    if (fetch) tick();
    for (int k = first; k <= last; k++) begin
      q.push_back('{$sformatf("%s_i%0d", tag, k + 1), exp_seq[k]});
      tick();
      pop_chk();
      if (k == 6) begin
        chk({tag, "_add_carry"}, {31'b0, carry}, 32'd1);
        chk({tag, "_add_ovf"}, {31'b0, overflow}, 32'd0);
      end
      if (k == 7) chk({tag, "_not_holds_carry"}, {31'b0, carry}, 32'd1);
      if (k == 9) chk({tag, "_add2_carry"}, {31'b0, carry}, 32'd0);
      if (k == 10) chk({tag, "_sub_noborrow"}, {31'b0, carry}, 32'd1);
      if (k == 13) chk({tag, "_comp_equal"}, {31'b0, equal}, 32'd0);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_carry", {31'b0, carry}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_equal", {31'b0, equal}, 32'd0);
    chk("ack_low", {31'b0, acknowledge}, 32'd0);
    request = 1;
    #1;
    chk("ack_in_rst", {31'b0, acknowledge}, 32'd1);
    request = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("unloaded_c%0d", i), dout, 32'h0);
    end
    rst = 1;
    request = 1;
    for (int a = 1; a <= 16; a++) begin
      addr = 6'(a);
      tick();
    end
    rst = 0;
    tick();
    chk("load_after_rst_dout", dout, 32'h0);
    request = 0;
    run("run1", 0, 15, 1);
    do_reset();
    run("pre_rst", 0, 8, 1);
    rst = 1;
    #1;
    chk("midrun_rst_dout", dout, 32'h0);
    chk("midrun_rst_carry", {31'b0, carry}, 32'd0);
    tick();
    rst = 0;
    run("rerun", 0, 15, 1);
    do_reset();
    run("stall_pre", 0, 4, 1);
    request = 1;
    addr = 6'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_dout_c%0d", i), dout, 32'h3);
      chk($sformatf("stall_ack_c%0d", i), {31'b0, acknowledge}, 32'd1);
    end
    request = 0;
    run("stall_post", 5, 15, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_processor.md
# mips_processor

Small single-issue 32-bit processor with an internal program ROM, a DMA-style load port that copies ROM words into instruction memory, a 16-entry register file and an ALU. Software or a bench loads instructions while `request` is high, then releases `rst` to run the program. Every write-back result is driven on `dout`, and ALU status is driven on `carry`, `overflow` and `equal`.

## Interface
- `aBit`, default 6: instruction address width (64 words).
- `nBit`, default 32: data and instruction width.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `request`, in, 1: high = load mode (DMA copy); low = execute.
- `addr`, in, `aBit`: load address.
- `dout`, out, `nBit`: last write-back value.
- `acknowledge`, out, 1: load accepted.
- `carry`, out, 1: ALU carry.
- `overflow`, out, 1: ALU signed overflow.
- `equal`, out, 1: compare result.

## Operation
- Instruction format:
  - `[31:28]` opcode, `[27:24]` rd, `[23:20]` rs, `[19:16]` rt, `[15:0]` imm.
  - Registers r0..r15; these are s0..s15.
- Opcodes:
  - 0 NOP.
  - 1 LI: rd = sign-extended imm.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, all rd = rs op rt.
  - 7 NOT: rd = ~rs.
  - 8 SLL: rd = rs << imm[4:0].
  - 9 MOV: rd = rs.
  - A COMP: rd = (rs==rt) ? 1 : 0 and equal = (rs==rt).
  - B..F behave as NOP.
- ADD/SUB are 33-bit.
  - carry = bit 32 of rs + rt, or of rs + ~rt + 1 (SUB carry = no-borrow).
  - overflow = signed overflow.
  - Flags hold on all other opcodes.
- Program ROM holds 64 words; all words not listed below are NOP. Listed words:
  - 1: LI r0,FFFF
  - 2: LI r1,1
  - 3: LI r2,2
  - 4: LI r3,0
  - 5: LI r4,3
  - 6: LI r5,4
  - 7: ADD r6,r1,r0
  - 8: NOT r7,r4
  - 9: SUB r8,r0,r1
  - 10: ADD r8,r1,r8
  - 11: SUB r8,r8,r2
  - 12: XOR r10,r0,r0
  - 13: AND r10,r2,r4
  - 14: COMP r10,r3,r0
  - 15: MOV r11,r5
  - 16: SLL r11,r0,1
- Load mode (request=1):
  - Each rising edge writes IMEM[addr] = ROM[addr].
  - IMEM is not cleared by `rst`; loading works while `rst` is high.
  - acknowledge = request (combinational).
- Execute (request=0, rst=0):
  - Two-stage fetch/execute. PC resets to 1.
  - Each edge: IR ← IMEM[PC], PC ← PC+1 (wraps 63→0), and the previous IR executes.
  - Write-back sets the register and `dout`; NOP leaves `dout` unchanged.
- Raising `request` during execute stalls PC and IR; loading proceeds, and execution resumes where it stopped when `request` falls.

## Timing
- Reset values: PC=1, IR=NOP, registers=0, `dout`=0, `carry`/`overflow`/`equal`=0.
- `acknowledge` follows `request` even while `rst` is high.
- Latency: the instruction at address n drives its result on `dout` after the (n+1)-th rising edge following `rst` deassertion with request=0. The first edge only fetches.
- `rst` asserted mid-run: immediate return to reset values; IMEM is kept.
- Simultaneous `request` and `rst` deassert: load continues, execution does not start.
- Register write and read of the same register in consecutive instructions: the read sees the new value (write at edge, read next cycle).

## Structure
- Package `mips_processor_pkg` contains:
  - opcode enum;
  - field position constants;
  - `rom_word(addr)` function holding the program.
- Sub-module `mips_alu`: combinational; inputs op, a, b, shamt; outputs result, carry, overflow, eq.
- Top holds IMEM (64×32), register file (16×32), PC, IR and flag registers.

## Test plan
- Load and execute:
  - Stimulus: rst=1, request=1, addr 1..16 stepped; then rst=0, request=0.
  - Response: after edge 1 no check. After edges 2..17, `dout` = FFFFFFFF, 1, 2, 0, 3, 4, 0, FFFFFFFC, FFFFFFFE, FFFFFFFF, FFFFFFFD, 0, 2, 0, 4, FFFFFFFE.
- Flags:
  - After instruction 7 (ADD 1+FFFFFFFF): carry=1, overflow=0.
  - After instruction 14: equal=0.
- Reset mid-run:
  - Stimulus: assert `rst` after instruction 9.
  - Response: `dout`=0 immediately. Rerun without reloading reproduces the same sequence.
- Stall:
  - Stimulus: request=1 for 3 cycles after instruction 5.
  - Response: `dout` holds 3, acknowledge=1, then the sequence continues with 4.
- Unloaded IMEM:
  - Stimulus: execute after power-up without a load.
  - Response: `dout` stays 0 for 20 cycles.
